// File: rtl/pcie_us_msi_mf_if.sv
`default_nettype none
// =============================================================================
// Module   : pcie_us_msi_mf_if
// Brief    : cfg_interrupt_msi_* bundle between the MSI shim and the PCIe core.
// Revision : 1.0
// =============================================================================
interface pcie_us_msi_mf_if;
    logic [3:0]  cfg_interrupt_msi_enable;
    logic [7:0]  cfg_interrupt_msi_vf_enable;
    logic [11:0] cfg_interrupt_msi_mmenable;
    logic        cfg_interrupt_msi_mask_update;
    logic [31:0] cfg_interrupt_msi_data;
    logic [3:0]  cfg_interrupt_msi_select;
    logic [31:0] cfg_interrupt_msi_int;
    logic [31:0] cfg_interrupt_msi_pending_status;
    logic        cfg_interrupt_msi_pending_status_data_enable;
    logic [3:0]  cfg_interrupt_msi_pending_status_function_num;
    logic        cfg_interrupt_msi_sent;
    logic        cfg_interrupt_msi_fail;
    logic [2:0]  cfg_interrupt_msi_attr;
    logic        cfg_interrupt_msi_tph_present;
    logic [1:0]  cfg_interrupt_msi_tph_type;
    logic [8:0]  cfg_interrupt_msi_tph_st_tag;
    logic [3:0]  cfg_interrupt_msi_function_number;

    modport master (
        input  cfg_interrupt_msi_enable, cfg_interrupt_msi_vf_enable,
               cfg_interrupt_msi_mmenable, cfg_interrupt_msi_mask_update,
               cfg_interrupt_msi_data, cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
        output cfg_interrupt_msi_select, cfg_interrupt_msi_int,
               cfg_interrupt_msi_pending_status,
               cfg_interrupt_msi_pending_status_data_enable,
               cfg_interrupt_msi_pending_status_function_num,
               cfg_interrupt_msi_attr, cfg_interrupt_msi_tph_present,
               cfg_interrupt_msi_tph_type, cfg_interrupt_msi_tph_st_tag,
               cfg_interrupt_msi_function_number
    );

    modport slave (
        output cfg_interrupt_msi_enable, cfg_interrupt_msi_vf_enable,
               cfg_interrupt_msi_mmenable, cfg_interrupt_msi_mask_update,
               cfg_interrupt_msi_data, cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
        input  cfg_interrupt_msi_select, cfg_interrupt_msi_int,
               cfg_interrupt_msi_pending_status,
               cfg_interrupt_msi_pending_status_data_enable,
               cfg_interrupt_msi_pending_status_function_num,
               cfg_interrupt_msi_attr, cfg_interrupt_msi_tph_present,
               cfg_interrupt_msi_tph_type, cfg_interrupt_msi_tph_st_tag,
               cfg_interrupt_msi_function_number
    );
endinterface
`default_nettype wire

// File: rtl/pcie_us_msi_mf.sv
`default_nettype none
// =============================================================================
// Module   : pcie_us_msi_mf
// Brief    : Multi-function MSI shim for the UltraScale PCIe cfg_interrupt_msi
//            interface with round-robin arbitration and response timeout.
// Revision : 1.0
// =============================================================================
module pcie_us_msi_mf #(
    parameter int MSI_COUNT = 32,
    parameter int PF_COUNT  = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PF_COUNT*MSI_COUNT-1:0] msi_irq,
    pcie_us_msi_mf_if.master              cfg,
    output logic                          stat_sent,
    output logic                          stat_fail,
    output logic                          stat_timeout
);
    localparam int c_NUM_VEC = PF_COUNT * MSI_COUNT;
    localparam int c_IDX_W   = (c_NUM_VEC > 1) ? $clog2(c_NUM_VEC) : 1;
    localparam int c_PF_W    = (PF_COUNT > 1) ? $clog2(PF_COUNT) : 1;
    localparam int c_VEC_W   = (MSI_COUNT > 1) ? $clog2(MSI_COUNT) : 1;
    localparam int c_TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [c_NUM_VEC-1:0]   irq_q, last_q;
    logic [c_NUM_VEC-1:0]   pending_q, pending_d;
    logic [c_NUM_VEC-1:0]   mask_q, mask_d;
    logic [c_PF_W-1:0]      sel_q, sel_d, sel_prev_q;
    logic [c_IDX_W-1:0]     rr_q, rr_d, grant_q, grant_d;
    logic [c_TMR_W-1:0]     tmr_q, tmr_d;
    logic [31:0]            int_q, int_d;
    logic [3:0]             fn_q, fn_d;
    logic                   sent_q, sent_d, fail_q, fail_d, tmo_q, tmo_d;
    logic                   den_q;

    logic [c_NUM_VEC-1:0]   w_req, w_clr;
    logic [c_IDX_W-1:0]     w_gnt;
    logic                   w_any;
    logic [c_VEC_W-1:0]     w_gnt_vec;
    logic [31:0]            w_pstat;
    int                     w_j;

    function automatic logic [MSI_COUNT-1:0] mme_mask(input logic [2:0] mme);
        logic [MSI_COUNT-1:0] m;
        m = '0;
        for (int i = 0; i < MSI_COUNT; i++) begin
            m[i] = (mme > 3'd4) || (i < (1 << mme));
        end
        return m;
    endfunction

    // Mask data is one cycle behind select, so it lands on the previous selection.
    always_comb begin
        mask_d = mask_q;
        sel_d  = (sel_q == c_PF_W'(PF_COUNT - 1)) ? '0 : sel_q + 1'b1;
        for (int p = 0; p < PF_COUNT; p++) begin
            if (sel_prev_q == c_PF_W'(p)) begin
                mask_d[p*MSI_COUNT +: MSI_COUNT] =
                    ~cfg.cfg_interrupt_msi_data[MSI_COUNT-1:0] &
                    mme_mask(cfg.cfg_interrupt_msi_mmenable[3*p +: 3]) &
                    {MSI_COUNT{cfg.cfg_interrupt_msi_enable[p]}};
            end
        end
    end

    always_comb begin
        w_pstat = '0;
        for (int p = 0; p < PF_COUNT; p++) begin
            if (sel_q == c_PF_W'(p)) begin
                w_pstat[MSI_COUNT-1:0] = pending_q[p*MSI_COUNT +: MSI_COUNT];
            end
        end
    end

    // Rotating priority: scan from rr_q upward with wrap, first request wins.
    always_comb begin
        w_req = pending_q & mask_q;
        w_any = 1'b0;
        w_gnt = '0;
        w_j   = 0;
        for (int k = 0; k < c_NUM_VEC; k++) begin
            w_j = int'(rr_q) + k;
            if (w_j >= c_NUM_VEC) begin
                w_j = w_j - c_NUM_VEC;
            end
            if (!w_any && w_req[w_j]) begin
                w_any = 1'b1;
                w_gnt = c_IDX_W'(w_j);
            end
        end
        w_gnt_vec = c_VEC_W'(int'(w_gnt) % MSI_COUNT);
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        int_d   = '0;
        fn_d    = fn_q;
        sent_d  = 1'b0;
        fail_d  = 1'b0;
        tmo_d   = 1'b0;
        w_clr   = '0;
        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    grant_d = w_gnt;
                    rr_d    = (int'(w_gnt) == c_NUM_VEC - 1) ? '0 : w_gnt + 1'b1;
                    int_d   = 32'd1 << w_gnt_vec;
                    fn_d    = 4'(int'(w_gnt) / MSI_COUNT);
                    tmr_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Sent takes priority when the core reports both.
                if (cfg.cfg_interrupt_msi_sent) begin
                    w_clr[grant_q] = 1'b1;
                    sent_d         = 1'b1;
                    state_d        = S_IDLE;
                end else if (cfg.cfg_interrupt_msi_fail) begin
                    fail_d  = 1'b1;
                    state_d = S_IDLE;
                end else if ((TIMEOUT != 0) && (tmr_q == c_TMR_W'(TIMEOUT))) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A new edge wins over the clear of the same bit.
        pending_d = (pending_q & ~w_clr) | (irq_q & ~last_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            irq_q      <= '0;
            last_q     <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            sel_q      <= '0;
            sel_prev_q <= '0;
            rr_q       <= '0;
            grant_q    <= '0;
            tmr_q      <= '0;
            int_q      <= '0;
            fn_q       <= '0;
            sent_q     <= 1'b0;
            fail_q     <= 1'b0;
            tmo_q      <= 1'b0;
            den_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_q      <= msi_irq;
            last_q     <= irq_q;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            sel_q      <= sel_d;
            sel_prev_q <= sel_q;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            tmr_q      <= tmr_d;
            int_q      <= int_d;
            fn_q       <= fn_d;
            sent_q     <= sent_d;
            fail_q     <= fail_d;
            tmo_q      <= tmo_d;
            den_q      <= 1'b1;
        end
    end

    assign cfg.cfg_interrupt_msi_select                      = 4'(sel_q);
    assign cfg.cfg_interrupt_msi_int                         = int_q;
    assign cfg.cfg_interrupt_msi_pending_status              = w_pstat;
    assign cfg.cfg_interrupt_msi_pending_status_data_enable  = den_q;
    assign cfg.cfg_interrupt_msi_pending_status_function_num = 4'(sel_q);
    assign cfg.cfg_interrupt_msi_function_number             = fn_q;
    assign cfg.cfg_interrupt_msi_attr                        = 3'd0;
    assign cfg.cfg_interrupt_msi_tph_present                 = 1'b0;
    assign cfg.cfg_interrupt_msi_tph_type                    = 2'd0;
    assign cfg.cfg_interrupt_msi_tph_st_tag                  = 9'd0;
    assign stat_sent    = sent_q;
    assign stat_fail    = fail_q;
    assign stat_timeout = tmo_q;

    logic w_unused;
    assign w_unused = ^{cfg.cfg_interrupt_msi_vf_enable, cfg.cfg_interrupt_msi_mask_update,
                        cfg.cfg_interrupt_msi_data, cfg.cfg_interrupt_msi_enable,
                        cfg.cfg_interrupt_msi_mmenable};
endmodule
`default_nettype wire

// File: tb/tb_pcie_us_msi_mf.sv
`default_nettype none
// =============================================================================
// Module   : tb_pcie_us_msi_mf
// Brief    : Directed self-checking bench for pcie_us_msi_mf (2 PFs, TIMEOUT=16).
// Revision : 1.0
// =============================================================================
module tb_pcie_us_msi_mf;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] irq;
    logic        stat_sent, stat_fail, stat_timeout;
    logic [31:0] core_mask [0:3];
    int          errors = 0;
    int          checks = 0;

    pcie_us_msi_mf_if u_if ();

    pcie_us_msi_mf #(.MSI_COUNT(32), .PF_COUNT(2), .TIMEOUT(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .msi_irq      (irq),
        .cfg          (u_if),
        .stat_sent    (stat_sent),
        .stat_fail    (stat_fail),
        .stat_timeout (stat_timeout)
    );

    always #5 clk = ~clk;

    // Core model: mask for the selected PF comes back one cycle later.
    always @(posedge clk) u_if.cfg_interrupt_msi_data <= core_mask[u_if.cfg_interrupt_msi_select];

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_irq(input logic [63:0] bits);
        irq = irq | bits;
        tick(1);
        irq = irq & ~bits;
    endtask

    task automatic wait_int(input string tag, input logic [31:0] exp, input logic [3:0] fn,
                            input int budget);
        int n;
        n = 0;
        while (u_if.cfg_interrupt_msi_int == 32'd0 && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_int"}, u_if.cfg_interrupt_msi_int, exp);
        check({tag, "_fn"}, 32'(u_if.cfg_interrupt_msi_function_number), 32'(fn));
    endtask

    task automatic respond_sent(input string tag);
        u_if.cfg_interrupt_msi_sent = 1'b1;
        tick(1);
        u_if.cfg_interrupt_msi_sent = 1'b0;
        check(tag, 32'(stat_sent), 32'd1);
    endtask

    task automatic quiet_for(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (u_if.cfg_interrupt_msi_int != 32'd0) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [3:0] s0;
        int         n;
        rst = 1'b1;
        irq = '0;
        for (int i = 0; i < 4; i++) core_mask[i] = 32'd0;
        u_if.cfg_interrupt_msi_enable      = 4'b0011;
        u_if.cfg_interrupt_msi_vf_enable   = 8'd0;
        u_if.cfg_interrupt_msi_mmenable    = 12'h02D;
        u_if.cfg_interrupt_msi_mask_update = 1'b0;
        u_if.cfg_interrupt_msi_sent        = 1'b0;
        u_if.cfg_interrupt_msi_fail        = 1'b0;

        // Reset state
        tick(3);
        check("rst_int", u_if.cfg_interrupt_msi_int, 32'd0);
        check("rst_den", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'd0);
        check("rst_sel", 32'(u_if.cfg_interrupt_msi_select), 32'd0);
        check("rst_pstat", u_if.cfg_interrupt_msi_pending_status, 32'd0);
        rst = 1'b0;
        tick(1);
        check("den_after_rst", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'd1);
        s0 = u_if.cfg_interrupt_msi_select;
        tick(1);
        check("sel_step", 32'(u_if.cfg_interrupt_msi_select), 32'((s0 + 4'd1) % 4'd2));
        check("fn_num_eq_sel", 32'(u_if.cfg_interrupt_msi_pending_status_function_num),
              32'((s0 + 4'd1) % 4'd2));
        tick(3);

        // Two PFs at once: PF0 first from reset pointer, then PF1
        pulse_irq(64'h0000_0001_0000_0001);
        tick(1);
        check("b_lat2", u_if.cfg_interrupt_msi_int, 32'd0);
        tick(1);
        check("b_int0", u_if.cfg_interrupt_msi_int, 32'h1);
        check("b_fn0", 32'(u_if.cfg_interrupt_msi_function_number), 32'd0);
        respond_sent("b_sent0");
        check("b_gap", u_if.cfg_interrupt_msi_int, 32'd0);
        tick(1);
        check("b_int1", u_if.cfg_interrupt_msi_int, 32'h1);
        check("b_fn1", 32'(u_if.cfg_interrupt_msi_function_number), 32'd1);
        respond_sent("b_sent1");
        tick(2);

        // Single vector latency on PF0 v3
        pulse_irq(64'h8);
        check("a_lat1", u_if.cfg_interrupt_msi_int, 32'd0);
        tick(1);
        check("a_lat2", u_if.cfg_interrupt_msi_int, 32'd0);
        tick(1);
        check("a_int", u_if.cfg_interrupt_msi_int, 32'h8);
        check("a_fn", 32'(u_if.cfg_interrupt_msi_function_number), 32'd0);
        respond_sent("a_stat_sent");
        check("a_one_cycle", u_if.cfg_interrupt_msi_int, 32'd0);
        tick(1);
        check("a_strobe_end", 32'(stat_sent), 32'd0);
        check("a_pend_clr", u_if.cfg_interrupt_msi_pending_status, 32'd0);

        // MME=1 on PF0: v5 outside the enabled range stays pending
        u_if.cfg_interrupt_msi_mmenable = 12'h029;
        tick(4);
        pulse_irq(64'h20);
        quiet_for("mme_no_int", 10);
        n = 0;
        while (u_if.cfg_interrupt_msi_select != 4'd0 && n < 4) begin
            tick(1);
            n++;
        end
        check("mme_pending", u_if.cfg_interrupt_msi_pending_status, 32'h20);
        u_if.cfg_interrupt_msi_mmenable = 12'h02D;
        wait_int("mme_release", 32'h20, 4'd0, 6);
        respond_sent("mme_sent");
        tick(2);

        // Masked by core mask bit 2, then unmasked
        core_mask[0] = 32'h4;
        tick(4);
        pulse_irq(64'h4);
        quiet_for("mask_no_int", 10);
        core_mask[0] = 32'h0;
        wait_int("unmask", 32'h4, 4'd0, 4);
        respond_sent("unmask_sent");
        tick(2);

        // Fail, retry, timeout, retry, sent
        pulse_irq(64'h80);
        wait_int("f_first", 32'h80, 4'd0, 4);
        u_if.cfg_interrupt_msi_fail = 1'b1;
        tick(1);
        u_if.cfg_interrupt_msi_fail = 1'b0;
        check("f_stat_fail", 32'(stat_fail), 32'd1);
        check("f_no_sent", 32'(stat_sent), 32'd0);
        wait_int("f_retry", 32'h80, 4'd0, 3);
        tick(16);
        check("t_not_yet", 32'(stat_timeout), 32'd0);
        tick(1);
        check("t_stat_timeout", 32'(stat_timeout), 32'd1);
        wait_int("t_retry", 32'h80, 4'd0, 3);
        respond_sent("t_sent");
        tick(2);

        // Reset during WAIT on PF1 v9
        pulse_irq(64'h0000_0200_0000_0000);
        wait_int("r_req", 32'h200, 4'd1, 4);
        rst = 1'b1;
        tick(1);
        check("r_int", u_if.cfg_interrupt_msi_int, 32'd0);
        check("r_fn", 32'(u_if.cfg_interrupt_msi_function_number), 32'd0);
        check("r_den", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'd0);
        rst = 1'b0;
        u_if.cfg_interrupt_msi_sent = 1'b1;
        tick(1);
        u_if.cfg_interrupt_msi_sent = 1'b0;
        check("r_late_sent", 32'(stat_sent), 32'd0);
        tick(1);
        check("r_late_sent2", 32'(stat_sent), 32'd0);
        check("r_pend_lost", u_if.cfg_interrupt_msi_pending_status, 32'd0);
        quiet_for("r_quiet", 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
